alu_bist_driver: RTL



---
 rtl/alu_bist_driver_pkg.sv | 51 +++++
 rtl/alu_bist_driver_misr.sv | 34 +++
 rtl/alu_bist_driver.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/alu_bist_driver_pkg.sv
// Shared constants, state encoding and helpers for the ALU self-test driver.
// The ALU_* codes mirror the core's defines.v register-register opcodes.
package alu_bist_driver_pkg;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;

    localparam int NUM_OPS = 10;

    localparam logic [31:0] BIST_LFSR_POLY = 32'h8020_0003;
    localparam logic [31:0] BIST_MISR_POLY = 32'h0040_0007;
    localparam logic [31:0] BIST_DIR_A     = 32'h401e_1042;
    localparam logic [31:0] BIST_DIR_B     = 32'h7fff_ffff;
    localparam logic [31:0] BIST_DIR_EXP   = 32'hc01e_1043;

    typedef enum logic [2:0] {
        BIST_S_IDLE    = 3'd0,
        BIST_S_LOAD    = 3'd1,
        BIST_S_APPLY   = 3'd2,
        BIST_S_CAPTURE = 3'd3,
        BIST_S_FINISH  = 3'd4
    } bist_state_e;

    function automatic logic [3:0] op_at(input logic [3:0] idx);
        case (idx)
            4'd0:    return ALU_ADD;
            4'd1:    return ALU_SUB;
            4'd2:    return ALU_SLL;
            4'd3:    return ALU_SLT;
            4'd4:    return ALU_SLTU;
            4'd5:    return ALU_XOR;
            4'd6:    return ALU_SRL;
            4'd7:    return ALU_SRA;
            4'd8:    return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        return (v >> 1) ^ (v[0] ? BIST_LFSR_POLY : 32'h0);
    endfunction

endpackage

// File: rtl/alu_bist_driver_misr.sv
// 32-bit MISR that folds each captured ALU result and zero flag into a signature.
module bist_misr32
    import alu_bist_driver_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        enable,
    input  logic [31:0] data_in,
    input  logic        zero_in,
    output logic [31:0] sig
);

    logic [31:0] sig_q;
    logic [31:0] sig_d;

    always_comb begin
        sig_d = sig_q;
        if (clear) begin
            sig_d = '0;
        end else if (enable) begin
            sig_d = ((sig_q << 1) ^ (sig_q[31] ? BIST_MISR_POLY : 32'h0))
                    ^ data_in ^ {31'b0, zero_in};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) sig_q <= '0;
        else        sig_q <= sig_d;
    end

    assign sig = sig_q;

endmodule

// File: rtl/alu_bist_driver.sv
// Power-on self-test driver: sweeps LFSR operand pairs through every ALU op,
// compresses the results in a MISR and compares against a golden signature.
module alu_bist_driver
    import alu_bist_driver_pkg::*;
#(
    parameter int          NUM_VECTORS = 4,
    parameter logic [31:0] SEED        = 32'hACE1_2468,
    parameter logic [31:0] GOLDEN_SIG  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [31:0] operand_a,
    output logic [31:0] operand_b,
    output logic [3:0]  alu_op,
    input  logic [31:0] alu_result,
    input  logic        zero_flag,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        sub_err,
    output logic [31:0] signature,
    output logic [15:0] vec_idx
);

    if (NUM_VECTORS < 1 || NUM_VECTORS > 65535) begin : g_bad_num_vectors
        $error("alu_bist_driver: NUM_VECTORS must be in 1..65535");
    end

    localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? 32'h0000_0001 : SEED;
    localparam logic [15:0] LAST_VEC = 16'(NUM_VECTORS - 1);
    localparam logic [3:0]  LAST_OP  = 4'(NUM_OPS - 1);

    bist_state_e state_q, state_d;
    logic [31:0] lfsr_q, lfsr_d;
    logic [31:0] operand_a_q, operand_a_d;
    logic [31:0] operand_b_q, operand_b_d;
    logic [3:0]  alu_op_q, alu_op_d;
    logic [3:0]  op_idx_q, op_idx_d;
    logic [15:0] vec_idx_q, vec_idx_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;
    logic        sub_err_q, sub_err_d;
    logic        misr_clear;
    logic        misr_en;
    logic [31:0] sig;

    always_comb begin
        state_d     = state_q;
        lfsr_d      = lfsr_q;
        operand_a_d = operand_a_q;
        operand_b_d = operand_b_q;
        alu_op_d    = alu_op_q;
        op_idx_d    = op_idx_q;
        vec_idx_d   = vec_idx_q;
        busy_d      = busy_q;
        done_d      = done_q;
        pass_d      = pass_q;
        sub_err_d   = sub_err_q;
        misr_clear  = 1'b0;
        misr_en     = 1'b0;

        case (state_q)
            BIST_S_IDLE: begin
                if (start) begin
                    state_d    = BIST_S_LOAD;
                    lfsr_d     = SEED_EFF;
                    vec_idx_d  = '0;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    pass_d     = 1'b0;
                    sub_err_d  = 1'b0;
                    misr_clear = 1'b1;
                end
            end
            BIST_S_LOAD: begin
                // Vector 0 is the directed SUB pair; later vectors consume two LFSR steps.
                if (vec_idx_q == 16'd0) begin
                    operand_a_d = BIST_DIR_A;
                    operand_b_d = BIST_DIR_B;
                end else begin
                    operand_a_d = lfsr_q;
                    operand_b_d = lfsr_step(lfsr_q);
                    lfsr_d      = lfsr_step(lfsr_step(lfsr_q));
                end
                alu_op_d = op_at(4'd0);
                op_idx_d = 4'd0;
                state_d  = BIST_S_CAPTURE;
            end
            BIST_S_APPLY: begin
                op_idx_d = op_idx_q + 4'd1;
                alu_op_d = op_at(op_idx_q + 4'd1);
                state_d  = BIST_S_CAPTURE;
            end
            BIST_S_CAPTURE: begin
                misr_en = 1'b1;
                if (vec_idx_q == 16'd0 && alu_op_q == ALU_SUB && alu_result != BIST_DIR_EXP) begin
                    sub_err_d = 1'b1;
                end
                if (op_idx_q < LAST_OP) begin
                    state_d = BIST_S_APPLY;
                end else if (vec_idx_q < LAST_VEC) begin
                    vec_idx_d = vec_idx_q + 16'd1;
                    state_d   = BIST_S_LOAD;
                end else begin
                    state_d = BIST_S_FINISH;
                end
            end
            BIST_S_FINISH: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                pass_d  = (sig == GOLDEN_SIG) && !sub_err_q;
                state_d = BIST_S_IDLE;
            end
            default: state_d = BIST_S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= BIST_S_IDLE;
            lfsr_q      <= '0;
            operand_a_q <= '0;
            operand_b_q <= '0;
            alu_op_q    <= '0;
            op_idx_q    <= '0;
            vec_idx_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            sub_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            operand_a_q <= operand_a_d;
            operand_b_q <= operand_b_d;
            alu_op_q    <= alu_op_d;
            op_idx_q    <= op_idx_d;
            vec_idx_q   <= vec_idx_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            sub_err_q   <= sub_err_d;
        end
    end

    bist_misr32 u_misr (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (misr_clear),
        .enable  (misr_en),
        .data_in (alu_result),
        .zero_in (zero_flag),
        .sig     (sig)
    );

    assign operand_a = operand_a_q;
    assign operand_b = operand_b_q;
    assign alu_op    = alu_op_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign sub_err   = sub_err_q;
    assign signature = sig;
    assign vec_idx   = vec_idx_q;

endmodule
